hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline. It is the consumer side of the IF/ID and ID/EX pipeline-register contents. It inspects the IF/ID instruction, the ID/EX control/rd fields and the MEM-stage branch/memory status, then drives write-enable, bubble and flush controls back into the IF/ID, ID/EX and EX/MEM registers. It also tracks refetch after a taken branch, data-memory wait timeouts and performance counters.

Parameters:
REFILL_CYCLES, 2, total cycles if_id_flush is asserted per taken branch (≥1)
MEM_TIMEOUT, 64, consecutive dmem wait cycles before mem_timeout_err sets
CNT_W, 16, width of stall/flush counters (saturating)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
if_id_instr  in  32  instruction in IF/ID (rs1=[19:15], rs2=[24:20], opcode=[6:0])
id_ex_mem_read  in  1  M_mem_read of instruction in ID/EX
id_ex_rd  in  5  rd of instruction in ID/EX
ex_mem_branch_taken  in  1  MEM-stage branch resolved taken (M_branch & zero)
dmem_req  in  1  MEM stage issuing a data-memory access this cycle
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
id_ex_bubble  out  1  zero all id_ex control fields on next load
if_id_flush  out  1  load NOP/zero into IF/ID
id_ex_flush  out  1  load zero control into ID/EX
ex_mem_flush  out  1  load zero control into EX/MEM
pipe_hold  out  1  hold ID/EX, EX/MEM, MEM/WB contents
mem_timeout_err  out  1  sticky timeout flag
stall_count  out  CNT_W  cycles with pc_write=0 for a hazard (load-use or mem wait)
flush_count  out  CNT_W  taken-branch flush events

Behaviour:
- Combinational outputs are derived from the inputs and the registered state. Counters and flags are registered.
- States: RUN, MEM_WAIT, REFILL. Refill counter is ceil(log2(REFILL_CYCLES+1)) bits.
- While rst=1: pc_write=0, if_id_write=0, id_ex_bubble=0, all three flushes=1, pipe_hold=0. Next state is RUN; counters=0; mem_timeout_err=0; wait count=0.
- Hazard detection:
  - mem_stall = dmem_req & ~dmem_ready.
  - uses_rs1 = opcode not in {0110111, 0010111, 1101111}.
  - uses_rs2 = opcode in {0110011, 0100011, 1100011}.
  - load_use = id_ex_mem_read & id_ex_rd≠0 & ((uses_rs1 & rs1==id_ex_rd) | (uses_rs2 & rs2==id_ex_rd)).
- Priority per cycle: mem_stall > branch > load_use.
- mem_stall, any state: pc_write=0, if_id_write=0, pipe_hold=1, no flush, no bubble. State becomes MEM_WAIT, or stays MEM_WAIT; the REFILL count freezes and resumes afterwards. stall_count increments.
- branch, in RUN or REFILL without mem_stall:
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, pc_write=1 (redirect), if_id_write=1.
  - flush_count increments.
  - If REFILL_CYCLES>1, go to REFILL with remaining=REFILL_CYCLES-1; otherwise go to RUN.
  - A branch during REFILL restarts the count.
- load_use, in RUN without mem_stall or branch: pc_write=0, if_id_write=0, id_ex_bubble=1. Lasts exactly one cycle, because the next cycle's ID/EX holds the bubble. stall_count increments.
- REFILL without mem_stall or branch: if_id_flush=1, pc_write=1. Decrement remaining; when it reaches 0, go to RUN. load_use is ignored, since IF/ID is being flushed.
- MEM_WAIT:
  - Wait counter increments per mem_stall cycle.
  - On reaching MEM_TIMEOUT, mem_timeout_err sets and stays set until rst.
  - When dmem_ready=1, the wait counter clears and the state returns to the pre-wait state (RUN or REFILL), tracked by a saved flag. That cycle evaluates normally.
- Idle (none of the above): pc_write=1, if_id_write=1, all others 0.
- Counters saturate at all-ones and never wrap.
- rst mid-MEM_WAIT or mid-REFILL takes effect on the next edge and overrides everything.

Test Plan:
- lw x5 in ID/EX (id_ex_mem_read=1, rd=5) with add x6,x5,x7 in IF/ID -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count=1. Repeat with rd=0 -> no stall.
- lw x5 in ID/EX with lui x5 in IF/ID -> no stall. With sw x9,0(x5) -> stall. With sw x5,0(x9), rs2 match -> stall.
- ex_mem_branch_taken pulse, REFILL_CYCLES=2 -> cycle 0: all three flushes=1; cycle 1: if_id_flush only; cycle 2: idle outputs; flush_count=1.
- Simultaneous branch + load_use + dmem_req with dmem_ready=0 for 3 cycles, then ready -> 3 cycles of pipe_hold=1 with no flush, then the flush cycle. stall_count=3.
- dmem_ready held low for 64 cycles (MEM_TIMEOUT=64) -> mem_timeout_err=1, which stays set after ready returns. Cleared only by rst.
- rst asserted during REFILL -> next cycle state RUN, counters 0. 2^CNT_W+5 stall cycles -> stall_count saturates at all-ones.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline registers and the stall/flush controller.
// The pipeline side (master) drives hazard status and the controller (slave) returns enables and flushes.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      if_id_instr;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rd;
  logic             ex_mem_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             pipe_hold;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_id_instr, id_ex_mem_read, id_ex_rd, ex_mem_branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
           pipe_hold, mem_timeout_err, stall_count, flush_count
  );

  modport slave (
    input  if_id_instr, id_ex_mem_read, id_ex_rd, ex_mem_branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
           pipe_hold, mem_timeout_err, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use bubbles, branch refill flushes,
// data-memory wait holds with a sticky timeout flag, and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int REFILL_CYCLES = 2,
  parameter int MEM_TIMEOUT   = 64,
  parameter int CNT_W         = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam int RW = $clog2(REFILL_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RW-1:0] REFILL_INIT  = RW'(REFILL_CYCLES - 1);
  localparam logic [WW-1:0] TIMEOUT_VAL  = WW'(MEM_TIMEOUT);
  localparam logic          MULTI_REFILL = (REFILL_CYCLES > 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {RUN, MEM_WAIT, REFILL} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    refill_q, refill_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             saved_refill_q, saved_refill_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;

  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2, load_use, mem_stall, branch, in_refill;

  assign opcode    = bus.if_id_instr[6:0];
  assign rs1       = bus.if_id_instr[19:15];
  assign rs2       = bus.if_id_instr[24:20];
  assign uses_rs1  = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign uses_rs2  = (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
  assign load_use  = bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
                     ((uses_rs1 && rs1 == bus.id_ex_rd) || (uses_rs2 && rs2 == bus.id_ex_rd));
  assign mem_stall = bus.dmem_req && !bus.dmem_ready;
  assign branch    = bus.ex_mem_branch_taken;
  // Leaving MEM_WAIT resumes whatever was interrupted, so refill is judged on the saved flag.
  assign in_refill = (state_q == REFILL) || (state_q == MEM_WAIT && saved_refill_q);

  always_comb begin
    pc_write       = 1'b0;
    if_id_write    = 1'b0;
    id_ex_bubble   = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    pipe_hold      = 1'b0;
    state_d        = state_q;
    refill_d       = refill_q;
    wait_d         = '0;
    saved_refill_d = saved_refill_q;
    err_d          = err_q;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    if (mem_stall) begin
      pipe_hold = 1'b1;
      stall_inc = 1'b1;
      state_d   = MEM_WAIT;
      if (state_q != MEM_WAIT) saved_refill_d = (state_q == REFILL);
      wait_d = (wait_q == TIMEOUT_VAL) ? wait_q : wait_q + 1'b1;
      if (wait_q >= TIMEOUT_VAL - 1'b1) err_d = 1'b1;
    end else if (branch) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      flush_inc    = 1'b1;
      state_d      = MULTI_REFILL ? REFILL : RUN;
      refill_d     = REFILL_INIT;
    end else if (in_refill) begin
      pc_write    = 1'b1;
      if_id_flush = 1'b1;
      refill_d    = refill_q - 1'b1;
      state_d     = (refill_q <= 1) ? RUN : REFILL;
    end else if (load_use) begin
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
      state_d      = RUN;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      state_d     = RUN;
    end

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      pipe_hold    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      refill_q       <= '0;
      wait_q         <= '0;
      saved_refill_q <= 1'b0;
      err_q          <= 1'b0;
      stall_q        <= '0;
      flush_q        <= '0;
    end else begin
      state_q        <= state_d;
      refill_q       <= refill_d;
      wait_q         <= wait_d;
      saved_refill_q <= saved_refill_d;
      err_q          <= err_d;
      if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (flush_inc && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_write        = pc_write;
  assign bus.if_id_write     = if_id_write;
  assign bus.id_ex_bubble    = id_ex_bubble;
  assign bus.if_id_flush     = if_id_flush;
  assign bus.id_ex_flush     = id_ex_flush;
  assign bus.ex_mem_flush    = ex_mem_flush;
  assign bus.pipe_hold       = pipe_hold;
  assign bus.mem_timeout_err = err_q;
  assign bus.stall_count     = stall_q;
  assign bus.flush_count     = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a vector table of single-cycle hazard cases from reset,
// then hand-written sequences for refill, memory waits, timeout, reset-in-refill and saturation.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Output order: pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold
  localparam logic [6:0] O_IDLE  = 7'b1100000;
  localparam logic [6:0] O_LU    = 7'b0010000;
  localparam logic [6:0] O_BR    = 7'b1101110;
  localparam logic [6:0] O_STALL = 7'b0000001;
  localparam logic [6:0] O_REF   = 7'b1001000;
  localparam logic [6:0] O_RST   = 7'b0001110;

  typedef struct {
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  rd;
    logic        br;
    logic        req;
    logic        rdy;
    logic [6:0]  exp_out;
    logic [3:0]  exp_stall;
    logic [3:0]  exp_flush;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[16];

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(
    .REFILL_CYCLES(2),
    .MEM_TIMEOUT  (64),
    .CNT_W        (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, 5'd1, op};
  endfunction

  function automatic logic [6:0] outs();
    return {bus.pc_write, bus.if_id_write, bus.id_ex_bubble, bus.if_id_flush,
            bus.id_ex_flush, bus.ex_mem_flush, bus.pipe_hold};
  endfunction

  task automatic applyStimulus(input logic [31:0] instr, input logic mr, input logic [4:0] rd,
                               input logic br, input logic req, input logic rdy);
    bus.if_id_instr         = instr;
    bus.id_ex_mem_read      = mr;
    bus.id_ex_rd            = rd;
    bus.ex_mem_branch_taken = br;
    bus.dmem_req            = req;
    bus.dmem_ready          = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOuts(input string name, input logic [6:0] exp);
    @(negedge clk);
    checkOutput(name, 32'(outs()), 32'(exp));
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{enc(OP_OP, 5'd5, 5'd7),     1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU,    4'd1, 4'd0};
    vecs[1]  = '{enc(OP_OP, 5'd5, 5'd7),     1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE,  4'd0, 4'd0};
    vecs[2]  = '{enc(OP_OP, 5'd5, 5'd7),     1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE,  4'd0, 4'd0};
    vecs[3]  = '{enc(OP_LUI, 5'd5, 5'd5),    1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE,  4'd0, 4'd0};
    vecs[4]  = '{enc(OP_STORE, 5'd5, 5'd9),  1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU,    4'd1, 4'd0};
    vecs[5]  = '{enc(OP_STORE, 5'd9, 5'd5),  1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU,    4'd1, 4'd0};
    vecs[6]  = '{enc(OP_IMM, 5'd7, 5'd5),    1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE,  4'd0, 4'd0};
    vecs[7]  = '{enc(OP_BRANCH, 5'd1, 5'd5), 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU,    4'd1, 4'd0};
    vecs[8]  = '{enc(OP_JAL, 5'd5, 5'd5),    1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE,  4'd0, 4'd0};
    vecs[9]  = '{enc(OP_AUIPC, 5'd5, 5'd5),  1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE,  4'd0, 4'd0};
    vecs[10] = '{enc(OP_OP, 5'd3, 5'd5),     1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU,    4'd1, 4'd0};
    vecs[11] = '{enc(OP_OP, 5'd1, 5'd2),     1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR,    4'd0, 4'd1};
    vecs[12] = '{enc(OP_OP, 5'd5, 5'd7),     1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_BR,    4'd0, 4'd1};
    vecs[13] = '{enc(OP_OP, 5'd5, 5'd7),     1'b1, 5'd5, 1'b1, 1'b1, 1'b0, O_STALL, 4'd1, 4'd0};
    vecs[14] = '{enc(OP_OP, 5'd5, 5'd7),     1'b1, 5'd5, 1'b0, 1'b1, 1'b1, O_LU,    4'd1, 4'd0};
    vecs[15] = '{enc(OP_OP, 5'd1, 5'd2),     1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE,  4'd0, 4'd0};

    // Reset state
    rst = 1'b1;
    applyStimulus(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOuts("reset_outputs", O_RST);
    tick();
    checkOutput("reset_stall_count", 32'(bus.stall_count), 32'd0);
    checkOutput("reset_flush_count", 32'(bus.flush_count), 32'd0);
    checkOutput("reset_timeout_err", 32'(bus.mem_timeout_err), 32'd0);

    for (int i = 0; i < 16; i++) begin
      doReset();
      applyStimulus(vecs[i].instr, vecs[i].mr, vecs[i].rd, vecs[i].br, vecs[i].req, vecs[i].rdy);
      checkOuts($sformatf("vec%0d_outputs", i), vecs[i].exp_out);
      tick();
      checkOutput($sformatf("vec%0d_stall_count", i), 32'(bus.stall_count), 32'(vecs[i].exp_stall));
      checkOutput($sformatf("vec%0d_flush_count", i), 32'(bus.flush_count), 32'(vecs[i].exp_flush));
    end

    // Branch refill: flush-all, if_id_flush only (load-use ignored), then idle
    doReset();
    applyStimulus(enc(OP_OP, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOuts("refill_c0", O_BR);
    tick();
    applyStimulus(enc(OP_OP, 5'd5, 5'd7), 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOuts("refill_c1", O_REF);
    tick();
    applyStimulus(enc(OP_OP, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOuts("refill_c2", O_IDLE);
    checkOutput("refill_flush_count", 32'(bus.flush_count), 32'd1);
    checkOutput("refill_stall_count", 32'(bus.stall_count), 32'd0);

    // Branch during REFILL restarts the refill
    doReset();
    applyStimulus(enc(OP_OP, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOuts("rebranch_c0", O_BR);
    tick();
    checkOuts("rebranch_c1", O_BR);
    tick();
    bus.ex_mem_branch_taken = 1'b0;
    checkOuts("rebranch_c2", O_REF);
    tick();
    checkOuts("rebranch_c3", O_IDLE);
    checkOutput("rebranch_flush_count", 32'(bus.flush_count), 32'd2);

    // Memory stall beats a simultaneous branch and load-use, then the branch wins on ready
    doReset();
    applyStimulus(enc(OP_OP, 5'd5, 5'd7), 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOuts($sformatf("combo_hold%0d", i), O_STALL);
      tick();
    end
    bus.dmem_ready = 1'b1;
    checkOuts("combo_ready", O_BR);
    tick();
    applyStimulus(enc(OP_OP, 5'd5, 5'd7), 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOuts("combo_refill", O_REF);
    tick();
    bus.id_ex_mem_read = 1'b0;
    checkOuts("combo_idle", O_IDLE);
    checkOutput("combo_stall_count", 32'(bus.stall_count), 32'd3);
    checkOutput("combo_flush_count", 32'(bus.flush_count), 32'd1);

    // Memory stall during REFILL freezes and then resumes the refill
    doReset();
    applyStimulus(enc(OP_OP, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOuts("frz_branch", O_BR);
    tick();
    applyStimulus(enc(OP_OP, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOuts($sformatf("frz_hold%0d", i), O_STALL);
      tick();
    end
    bus.dmem_ready = 1'b1;
    checkOuts("frz_resume", O_REF);
    tick();
    bus.dmem_req = 1'b0;
    checkOuts("frz_idle", O_IDLE);
    checkOutput("frz_stall_count", 32'(bus.stall_count), 32'd2);
    checkOutput("frz_flush_count", 32'(bus.flush_count), 32'd1);

    // Timeout at 64 wait cycles, sticky until reset; stall_count saturates at 15
    doReset();
    applyStimulus(enc(OP_OP, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 63; i++) tick();
    checkOutput("timeout_63", 32'(bus.mem_timeout_err), 32'd0);
    tick();
    checkOutput("timeout_64", 32'(bus.mem_timeout_err), 32'd1);
    checkOutput("stall_saturate", 32'(bus.stall_count), 32'd15);
    bus.dmem_ready = 1'b1;
    checkOuts("timeout_ready_outputs", O_IDLE);
    tick();
    applyStimulus(enc(OP_OP, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("timeout_sticky", 32'(bus.mem_timeout_err), 32'd1);
    checkOutput("stall_still_saturated", 32'(bus.stall_count), 32'd15);
    doReset();
    checkOutput("timeout_cleared", 32'(bus.mem_timeout_err), 32'd0);
    checkOutput("timeout_stall_cleared", 32'(bus.stall_count), 32'd0);

    // Reset in the middle of REFILL returns straight to RUN
    doReset();
    applyStimulus(enc(OP_OP, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    bus.ex_mem_branch_taken = 1'b0;
    checkOuts("rst_in_refill_outputs", O_RST);
    tick();
    rst = 1'b0;
    checkOuts("post_rst_run", O_IDLE);
    checkOutput("post_rst_flush_count", 32'(bus.flush_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
